adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder_if.sv | 10 +
 rtl/adc_spi_responder.sv | 152 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// SPI bus between the ADC interface master and the emulated ADC responder.
interface adc_spi_responder_if;
    logic csn;
    logic sck;
    logic sdi;
    logic sdo;

    modport master (output csn, output sck, output sdi, input sdo);
    modport slave  (input csn, input sck, input sdi, output sdo);
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates a 2-channel 8-bit SPI ADC: synchronizes the bus into sys_clk, shifts out
// {4'b0, sample, 4'b0} and captures ADD2..ADD0 from DIN to select the next channel.
module adc_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [7:0]                ch0_data,
    input  logic [7:0]                ch1_data,
    adc_spi_responder_if.slave        spi,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      cur_chan,
    output logic [2:0]                addr_latched
);

    typedef enum logic [1:0] {StIdle, StArmed, StShift, StDone} state_e;

    localparam logic [4:0] LastRise = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   csn_prev_q;
    logic                   sck_prev_q;

    logic csn_s, sck_s, sdi_s;
    logic csn_fall, csn_rise, sck_fall, sck_rise;

    state_e                state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [4:0]            rise_cnt_q;
    logic [2:0]            addr_shadow_q;
    logic [2:0]            addr_latched_q;
    logic                  next_chan_q;
    logic                  cur_chan_q;
    logic                  sdo_q;
    logic                  frame_done_q;
    logic                  frame_abort_q;
    logic [7:0]            sample;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            csn_sync_q <= '0;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            csn_prev_q <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            csn_sync_q[0] <= spi.csn;
            sck_sync_q[0] <= spi.sck;
            sdi_sync_q[0] <= spi.sdi;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                csn_sync_q[i] <= csn_sync_q[i-1];
                sck_sync_q[i] <= sck_sync_q[i-1];
                sdi_sync_q[i] <= sdi_sync_q[i-1];
            end
            csn_prev_q <= csn_s;
            sck_prev_q <= sck_s;
        end
    end

    always_comb begin
        csn_s    = csn_sync_q[SYNC_STAGES-1];
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        sdi_s    = sdi_sync_q[SYNC_STAGES-1];
        csn_fall = csn_prev_q & ~csn_s;
        csn_rise = ~csn_prev_q & csn_s;
        sck_fall = sck_prev_q & ~sck_s;
        sck_rise = ~sck_prev_q & sck_s;
        sample   = next_chan_q ? ch1_data : ch0_data;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= StIdle;
            frame_q        <= '0;
            rise_cnt_q     <= '0;
            addr_shadow_q  <= '0;
            addr_latched_q <= '0;
            next_chan_q    <= 1'b0;
            cur_chan_q     <= 1'b0;
            sdo_q          <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_abort_q  <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sdo_q <= 1'b0;
                    if (csn_s) state_q <= StArmed;
                end
                StArmed: begin
                    sdo_q <= 1'b0;
                    // sck edges coincident with the csn fall are dropped here by construction
                    if (csn_fall) begin
                        state_q       <= StShift;
                        frame_q       <= {4'b0000, sample, 4'b0000};
                        sdo_q         <= 1'b0;
                        cur_chan_q    <= next_chan_q;
                        addr_shadow_q <= '0;
                        rise_cnt_q    <= '0;
                    end
                end
                StShift: begin
                    if (csn_rise) begin
                        sdo_q      <= 1'b0;
                        rise_cnt_q <= '0;
                        if (rise_cnt_q == LastRise) begin
                            state_q        <= StDone;
                            frame_done_q   <= 1'b1;
                            addr_latched_q <= addr_shadow_q;
                            next_chan_q    <= addr_shadow_q[0];
                        end else begin
                            state_q       <= StArmed;
                            frame_abort_q <= 1'b1;
                        end
                    end else if (sck_rise && (rise_cnt_q < LastRise)) begin
                        rise_cnt_q <= rise_cnt_q + 5'd1;
                        // rise_cnt_q is the 0-based index of this edge: edges 3..5 carry ADD2..ADD0
                        case (rise_cnt_q)
                            5'd2:    addr_shadow_q[2] <= sdi_s;
                            5'd3:    addr_shadow_q[1] <= sdi_s;
                            5'd4:    addr_shadow_q[0] <= sdi_s;
                            default: ;
                        endcase
                    end else if (sck_fall) begin
                        frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                        sdo_q   <= frame_q[FRAME_BITS-2];
                    end
                end
                StDone: begin
                    sdo_q   <= 1'b0;
                    state_q <= StArmed;
                end
                default: begin
                    sdo_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign spi.sdo      = sdo_q;
    assign frame_done   = frame_done_q;
    assign frame_abort  = frame_abort_q;
    assign cur_chan     = cur_chan_q;
    assign addr_latched = addr_latched_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: an SPI master model drives frames and a
// scoreboard queue holds the DOUT bits each frame must produce.
module tb_adc_spi_responder;

    localparam time HALF = 80ns;

    logic       sys_clk;
    logic       rst;
    logic [7:0] ch0_data;
    logic [7:0] ch1_data;
    logic       frame_done;
    logic       frame_abort;
    logic       cur_chan;
    logic [2:0] addr_latched;

    adc_spi_responder_if bus ();

    adc_spi_responder #(
        .SYNC_STAGES (2),
        .FRAME_BITS  (16)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .ch0_data     (ch0_data),
        .ch1_data     (ch1_data),
        .spi          (bus),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .cur_chan     (cur_chan),
        .addr_latched (addr_latched)
    );

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    logic sdo_exp_q[$];
    logic m_next_chan = 1'b0;

    initial sys_clk = 1'b0;
    always #5ns sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one frame with n_rise sck rising edges. coincident puts an sck rise on the same
    // instant as the csn fall. peek_k samples rise_cnt after that rising edge.
    task automatic spi_frame(input string name, input int n_rise, input logic [2:0] addr,
                             input bit coincident, input bit check_sdo, input int peek_k);
        logic [7:0]  smp;
        logic [15:0] word;
        logic        exp_cur;
        logic        bit_exp;
        logic [4:0]  cnt_exp;
        int          d0, a0;
        bit          exp_done;

        exp_cur  = m_next_chan;
        smp      = m_next_chan ? ch1_data : ch0_data;
        word     = {4'b0000, smp, 4'b0000};
        exp_done = (n_rise >= 16);
        for (int k = 1; k <= n_rise; k++) sdo_exp_q.push_back(k <= 16 ? word[16-k] : 1'b0);
        d0 = done_cnt;
        a0 = abort_cnt;

        if (coincident) begin
            bus.csn = 1'b0;
            bus.sck = 1'b1;
            #HALF;
            bus.sck = 1'b0;
        end else begin
            bus.csn = 1'b0;
        end
        #HALF;
        for (int k = 1; k <= n_rise; k++) begin
            bus.sdi = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom_range(0, 1));
            #HALF;
            bit_exp = sdo_exp_q.pop_front();
            if (check_sdo) begin
                checks++;
                if (bus.sdo !== bit_exp) begin
                    errors++;
                    $display("FAIL %s sdo bit %0d: got %b expected %b", name, k, bus.sdo,
                             bit_exp);
                end
            end
            bus.sck = 1'b1;
            #HALF;
            if (k == peek_k) begin
                cnt_exp = (k > 16) ? 5'd16 : 5'(k);
                checks++;
                if (dut.rise_cnt_q !== cnt_exp) begin
                    errors++;
                    $display("FAIL %s rise_cnt after edge %0d: got %0d expected %0d", name, k,
                             dut.rise_cnt_q, cnt_exp);
                end
            end
            bus.sck = 1'b0;
        end
        #HALF;
        bus.csn = 1'b1;
        #200ns;

        checks++;
        if ((done_cnt - d0) !== (exp_done ? 1 : 0)) begin
            errors++;
            $display("FAIL %s frame_done pulses: got %0d expected %0d", name, done_cnt - d0,
                     exp_done ? 1 : 0);
        end
        checks++;
        if ((abort_cnt - a0) !== (exp_done ? 0 : 1)) begin
            errors++;
            $display("FAIL %s frame_abort pulses: got %0d expected %0d", name, abort_cnt - a0,
                     exp_done ? 0 : 1);
        end
        checks++;
        if (cur_chan !== exp_cur) begin
            errors++;
            $display("FAIL %s cur_chan: got %b expected %b", name, cur_chan, exp_cur);
        end
        if (exp_done) m_next_chan = addr[0];
        checks++;
        if (bus.sdo !== 1'b0) begin
            errors++;
            $display("FAIL %s sdo after csn high: got %b expected 0", name, bus.sdo);
        end
    endtask

    task automatic check_addr(input string name, input logic [2:0] exp);
        checks++;
        if (addr_latched !== exp) begin
            errors++;
            $display("FAIL %s addr_latched: got %b expected %b", name, addr_latched, exp);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.csn  = 1'b1;
        bus.sck  = 1'b0;
        bus.sdi  = 1'b0;
        ch0_data = 8'hA5;
        ch1_data = 8'h3C;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (bus.sdo !== 1'b0) begin
            errors++;
            $display("FAIL reset sdo: got %b expected 0", bus.sdo);
        end
        checks++;
        if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: got done=%b abort=%b expected 0/0", frame_done,
                     frame_abort);
        end
        checks++;
        if (cur_chan !== 1'b0) begin
            errors++;
            $display("FAIL reset cur_chan: got %b expected 0", cur_chan);
        end
        check_addr("reset", 3'b000);
        rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        m_next_chan = 1'b0;
    endtask

    task automatic test_basic();
        spi_frame("basic", 16, 3'b000, 1'b0, 1'b1, 0);
        check_addr("basic", 3'b000);
    endtask

    task automatic test_addr_chan();
        spi_frame("addr_f1", 16, 3'b001, 1'b0, 1'b1, 0);
        check_addr("addr_f1", 3'b001);
        spi_frame("addr_f2", 16, 3'b110, 1'b0, 1'b1, 0);
        check_addr("addr_f2", 3'b110);
    endtask

    task automatic test_abort();
        spi_frame("abort", 9, 3'b001, 1'b0, 1'b1, 0);
        check_addr("abort", 3'b110);
        spi_frame("after_abort", 16, 3'b011, 1'b0, 1'b1, 0);
        check_addr("after_abort", 3'b011);
    endtask

    task automatic test_reset_mid();
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        bus.csn = 1'b0;
        #HALF;
        for (int k = 0; k < 6; k++) begin
            bus.sck = 1'b1;
            #HALF;
            bus.sck = 1'b0;
            #HALF;
        end
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        m_next_chan = 1'b0;
        checks++;
        if (cur_chan !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cur_chan: got %b expected 0", cur_chan);
        end
        check_addr("reset_mid", 3'b000);
        for (int k = 0; k < 4; k++) begin
            bus.sck = 1'b1;
            #HALF;
            bus.sck = 1'b0;
            #HALF;
            checks++;
            if (bus.sdo !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid sdo cycle %0d: got %b expected 0", k, bus.sdo);
            end
        end
        bus.csn = 1'b1;
        #200ns;
        checks++;
        if ((done_cnt - d0) !== 0 || (abort_cnt - a0) !== 0) begin
            errors++;
            $display("FAIL reset_mid pulses: got done=%0d abort=%0d expected 0/0",
                     done_cnt - d0, abort_cnt - a0);
        end
        spi_frame("post_reset", 16, 3'b010, 1'b0, 1'b1, 0);
        check_addr("post_reset", 3'b010);
    endtask

    task automatic test_long();
        spi_frame("long", 20, 3'b101, 1'b0, 1'b1, 20);
        check_addr("long", 3'b101);
    endtask

    task automatic test_coincident();
        spi_frame("coincident", 16, 3'b100, 1'b1, 1'b0, 15);
        check_addr("coincident", 3'b100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_chan();
        test_abort();
        test_reset_mid();
        test_long();
        test_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
